control_sequencer: RTL

Hardwired Moore control unit that drives the control inputs of `Datapath2`, replacing the hand-sequenced T0–T7 stimulus used when bringing up the datapath. It sits directly upstream of the datapath: it reads the datapath's IR and emits, each clock, the bus-select, register-load, memory and ALU-op signals needed to fetch and execute one instruction. Supported instructions are ld, ldi, st, add, sub, addi, nop and halt.

---
 rtl/control_sequencer_if.sv | 27 ++
 rtl/control_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between control_sequencer and the Datapath2 control inputs.
// The master side is the sequencer: it reads IR/Stop and drives every control line.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, Zlowout, MDRout, Rout, BAout, Cout;
    logic        MARin, MDRin, IRin, PCin, Yin, Zin, Rin;
    logic        Gra, Grb, Grc;
    logic        Read, Write;
    logic [4:0]  ALU_Control;
    logic        Run;
    logic [3:0]  Present_state;

    modport master (
        input  IR, Stop,
        output PCout, Zlowout, MDRout, Rout, BAout, Cout,
        output MARin, MDRin, IRin, PCin, Yin, Zin, Rin,
        output Gra, Grb, Grc, Read, Write, ALU_Control, Run, Present_state
    );

    modport slave (
        output IR, Stop,
        input  PCout, Zlowout, MDRout, Rout, BAout, Cout,
        input  MARin, MDRin, IRin, PCin, Yin, Zin, Rin,
        input  Gra, Grb, Grc, Read, Write, ALU_Control, Run, Present_state
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for Datapath2: fetches and executes ld, ldi, st,
// add, sub, addi, nop and halt; memory states are stretched to MEM_CYCLES clocks.
module control_sequencer #(
    parameter int unsigned MEM_CYCLES = 1,
    parameter logic [4:0]  ALU_ADD    = 5'd2,
    parameter logic [4:0]  ALU_SUB    = 5'd3,
    parameter logic [4:0]  ALU_INC    = 5'd12
) (
    input logic                  clk,
    input logic                  clr,
    control_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000,
        OP_LDI  = 5'b00001,
        OP_ST   = 5'b00010,
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_ADDI = 5'b01100,
        OP_NOP  = 5'b11010,
        OP_HALT = 5'b11011
    } opcode_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_CYCLES - 1);

    state_t     state;
    logic [2:0] wait_cnt;
    logic [4:0] opcode;
    state_t     ret_state;
    logic       first_mem;

    assign opcode    = bus.IR[31:27];
    assign ret_state = bus.Stop ? S_HALT : S_T0;
    // Counter is loaded only on entry, so it still holds WAIT_INIT on the first cycle.
    assign first_mem = (wait_cnt == WAIT_INIT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_RESET;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_RESET: state <= S_T0;
                S_T0: begin
                    state    <= S_T1;
                    wait_cnt <= WAIT_INIT;
                end
                S_T1: begin
                    if (wait_cnt == 3'd0) state <= S_T2;
                    else                  wait_cnt <= wait_cnt - 3'd1;
                end
                S_T2: begin
                    case (opcode)
                        OP_HALT: state <= S_HALT;
                        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_ADDI: state <= S_T3;
                        default: state <= ret_state;
                    endcase
                end
                S_T3: state <= S_T4;
                S_T4: state <= S_T5;
                S_T5: begin
                    case (opcode)
                        OP_LD: begin
                            state    <= S_T6;
                            wait_cnt <= WAIT_INIT;
                        end
                        OP_ST:   state <= S_T6;
                        default: state <= ret_state;
                    endcase
                end
                S_T6: begin
                    if (opcode == OP_ST) begin
                        state    <= S_T7;
                        wait_cnt <= WAIT_INIT;
                    end else if (wait_cnt == 3'd0) begin
                        state <= S_T7;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_T7: begin
                    if (opcode == OP_ST && wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
                    else                                     state <= ret_state;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        bus.PCout       = 1'b0;
        bus.Zlowout     = 1'b0;
        bus.MDRout      = 1'b0;
        bus.Rout        = 1'b0;
        bus.BAout       = 1'b0;
        bus.Cout        = 1'b0;
        bus.MARin       = 1'b0;
        bus.MDRin       = 1'b0;
        bus.IRin        = 1'b0;
        bus.PCin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Zin         = 1'b0;
        bus.Rin         = 1'b0;
        bus.Gra         = 1'b0;
        bus.Grb         = 1'b0;
        bus.Grc         = 1'b0;
        bus.Read        = 1'b0;
        bus.Write       = 1'b0;
        bus.ALU_Control = '0;
        bus.Run         = (state != S_RESET) && (state != S_HALT);
        bus.Present_state = state;

        case (state)
            S_T0: begin
                bus.PCout       = 1'b1;
                bus.MARin       = 1'b1;
                bus.Zin         = 1'b1;
                bus.ALU_Control = ALU_INC;
            end
            S_T1: begin
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.Zlowout = first_mem;
                bus.PCin    = first_mem;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                bus.Grb = 1'b1;
                bus.Yin = 1'b1;
                if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST) bus.BAout = 1'b1;
                else                                                        bus.Rout  = 1'b1;
            end
            S_T4: begin
                bus.Zin = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    bus.Grc         = 1'b1;
                    bus.Rout        = 1'b1;
                    bus.ALU_Control = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                end else begin
                    bus.Cout        = 1'b1;
                    bus.ALU_Control = ALU_ADD;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (opcode == OP_LD || opcode == OP_ST) begin
                    bus.MARin = 1'b1;
                end else begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end
            end
            S_T6: begin
                bus.MDRin = 1'b1;
                if (opcode == OP_ST) begin
                    bus.Gra  = 1'b1;
                    bus.Rout = 1'b1;
                end else begin
                    bus.Read = 1'b1;
                end
            end
            S_T7: begin
                if (opcode == OP_ST) begin
                    bus.Write = 1'b1;
                end else begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
